pll_lock_rst_ctrl: RTL and testbench



---
 rtl/pll_lock_rst_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pll_lock_rst_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_rst_ctrl.sv
// PLL reset sequencer: drives pll_rst, qualifies pll_lock, releases sys_rst_n.
// Optional lock-loss counter enabled by defining PLL_LOCK_LOSS_CNT_EN.
module pll_lock_rst_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 7,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             pll_ready,
  output logic             pll_fail,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ?
                          RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C  = (MAX_AB > STABLE_CYCLES) ?
                          MAX_AB : STABLE_CYCLES;
  localparam int TW     = $clog2(MAX_C + 1);

  localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STB_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] CNT_ONE  = TW'(1);
  localparam logic [7:0]    RTY_MAX  = 8'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  logic          r_sync1;
  logic          r_lock_s;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_cnt;
  logic [TW-1:0] w_cnt_nxt;
  logic [7:0]    r_retry;
  logic [7:0]    w_retry_nxt;
  logic          r_pll_rst;
  logic          r_sys_rst_n;
  logic          r_pll_ready;
  logic          r_pll_fail;

  // pll_lock is asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= pll_lock;
      r_lock_s <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_PLL_RST;
      r_cnt   <= '0;
      r_retry <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_retry <= w_retry_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
    unique case (r_state)
      S_PLL_RST: begin
        if (r_cnt == RST_LAST) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_WAIT_LOCK: begin
        if (r_lock_s) begin
          w_state_nxt = S_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TO_LAST) begin
          w_cnt_nxt   = '0;
          w_retry_nxt = r_retry + 8'd1;
          w_state_nxt = (w_retry_nxt == RTY_MAX) ?
                        S_FAIL : S_PLL_RST;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_STABLE: begin
        if (!r_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STB_LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
          w_retry_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_RUN: begin
        if (!r_lock_s) begin
          w_state_nxt = S_PLL_RST;
          w_cnt_nxt   = '0;
        end
      end
      S_FAIL: begin
        w_state_nxt = S_FAIL;
      end
      default: begin
        w_state_nxt = S_PLL_RST;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs registered from next state so they track state_o exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_pll_ready <= 1'b0;
      r_pll_fail  <= 1'b0;
    end else begin
      r_pll_rst   <= (w_state_nxt == S_PLL_RST) ||
                     (w_state_nxt == S_FAIL);
      r_sys_rst_n <= (w_state_nxt == S_RUN);
      r_pll_ready <= (w_state_nxt == S_RUN);
      r_pll_fail  <= (w_state_nxt == S_FAIL);
    end
  end

`ifdef PLL_LOCK_LOSS_CNT_EN
  logic             w_loss;
  logic [CNT_W-1:0] r_loss_cnt;

  assign w_loss = (r_state == S_RUN) && !r_lock_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_loss_cnt <= '0;
    end else if (w_loss && (r_loss_cnt != '1)) begin
      r_loss_cnt <= r_loss_cnt + CNT_W'(1);
    end
  end

  assign lock_loss_cnt = r_loss_cnt;
`else
  assign lock_loss_cnt = '0;
`endif

  assign pll_rst   = r_pll_rst;
  assign sys_rst_n = r_sys_rst_n;
  assign pll_ready = r_pll_ready;
  assign pll_fail  = r_pll_fail;
  assign state_o   = r_state;

endmodule

// File: tb/tb_pll_lock_rst_ctrl.sv
// Bench for pll_lock_rst_ctrl: vector table, corner sequences, random vs model.
// Honors PLL_LOCK_LOSS_CNT_EN for the expected lock-loss count.
module tb_pll_lock_rst_ctrl;

  localparam int RSTC = 4;
  localparam int TOC  = 32;
  localparam int STBC = 8;
  localparam int MAXR = 2;
  localparam int CW   = 8;
  localparam int SAT  = (1 << CW) - 1;
`ifdef PLL_LOCK_LOSS_CNT_EN
  localparam int LE = 1;
`else
  localparam int LE = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pll_lock = 1'b0;
  logic          pll_rst;
  logic          sys_rst_n;
  logic          pll_ready;
  logic          pll_fail;
  logic [2:0]    state_o;
  logic [CW-1:0] lock_loss_cnt;

  pll_lock_rst_ctrl #(
    .RST_CYCLES(RSTC),
    .LOCK_TIMEOUT(TOC),
    .STABLE_CYCLES(STBC),
    .MAX_RETRY(MAXR),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pll_lock(pll_lock),
    .pll_rst(pll_rst),
    .sys_rst_n(sys_rst_n),
    .pll_ready(pll_ready),
    .pll_fail(pll_fail),
    .state_o(state_o),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase, cycles spent in it, retries, losses
  int m_ph, m_age, m_retry, m_loss;
  bit hist[$];

  function void model_reset();
    m_ph = 0; m_age = 0; m_retry = 0; m_loss = 0;
    hist.delete();
  endfunction

  function void model_step();
    bit ls;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ls = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
    hist.push_back(pll_lock);
    if (hist.size() > 4) void'(hist.pop_front());
    if (m_ph == 0) begin
      m_age++;
      if (m_age == RSTC) begin m_ph = 1; m_age = 0; end
    end else if (m_ph == 1) begin
      if (ls) begin
        m_ph = 2; m_age = 0;
      end else begin
        m_age++;
        if (m_age == TOC) begin
          m_retry++;
          m_age = 0;
          m_ph = (m_retry == MAXR) ? 4 : 0;
        end
      end
    end else if (m_ph == 2) begin
      if (!ls) begin
        m_ph = 1; m_age = 0;
      end else begin
        m_age++;
        if (m_age == STBC) begin
          m_ph = 3; m_age = 0; m_retry = 0;
        end
      end
    end else if (m_ph == 3) begin
      if (!ls) begin
        m_ph = 0; m_age = 0;
        if (m_loss < SAT) m_loss++;
      end
    end
  endfunction

  function void check_all();
    bit er, es, ey, ef;
    int el;
    er = (m_ph == 0) || (m_ph == 4);
    es = (m_ph == 3);
    ey = (m_ph == 3);
    ef = (m_ph == 4);
    el = LE ? m_loss : 0;
    n_vec++;
    if (pll_rst !== er || sys_rst_n !== es || pll_ready !== ey ||
        pll_fail !== ef || int'(state_o) != m_ph ||
        int'(lock_loss_cnt) != el) begin
      n_err++;
      $display("FAIL model t=%0t got rst=%b sys=%b rdy=%b fail=%b st=%0d loss=%0d need rst=%b sys=%b rdy=%b fail=%b st=%0d loss=%0d",
               $time, pll_rst, sys_rst_n, pll_ready, pll_fail,
               state_o, lock_loss_cnt, er, es, ey, ef, m_ph, el);
    end
  endfunction

  function void expect_eq(string nm, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d need %0d t=%0t", nm, got, exp, $time);
    end
  endfunction

  task automatic cyc(input bit lk);
    pll_lock = lk;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input bit lk, input int n);
    for (int i = 0; i < n; i++) cyc(lk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    run(1'b0, 2);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit lk;
    int n;
    int st;
    bit prst;
    bit srst;
    int loss;
  } vec_t;

  vec_t tbl[19];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int runs[$];
    bit prev;
    int len;
    bit rl;
    int seg;

    tbl[0]  = '{1'b0, 3, 0, 1'b1, 1'b0, 0};
    tbl[1]  = '{1'b0, 1, 1, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b0, 9, 1, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b1, 2, 1, 1'b0, 1'b0, 0};
    tbl[4]  = '{1'b1, 1, 2, 1'b0, 1'b0, 0};
    tbl[5]  = '{1'b1, 7, 2, 1'b0, 1'b0, 0};
    tbl[6]  = '{1'b1, 1, 3, 1'b0, 1'b1, 0};
    tbl[7]  = '{1'b0, 1, 3, 1'b0, 1'b1, 0};
    tbl[8]  = '{1'b1, 1, 3, 1'b0, 1'b1, 0};
    tbl[9]  = '{1'b1, 1, 0, 1'b1, 1'b0, LE};
    tbl[10] = '{1'b1, 3, 0, 1'b1, 1'b0, LE};
    tbl[11] = '{1'b1, 1, 1, 1'b0, 1'b0, LE};
    tbl[12] = '{1'b1, 1, 2, 1'b0, 1'b0, LE};
    tbl[13] = '{1'b0, 1, 2, 1'b0, 1'b0, LE};
    tbl[14] = '{1'b1, 1, 2, 1'b0, 1'b0, LE};
    tbl[15] = '{1'b1, 1, 1, 1'b0, 1'b0, LE};
    tbl[16] = '{1'b1, 1, 2, 1'b0, 1'b0, LE};
    tbl[17] = '{1'b1, 7, 2, 1'b0, 1'b0, LE};
    tbl[18] = '{1'b1, 1, 3, 1'b0, 1'b1, LE};

    model_reset();
    run(1'b0, 3);
    expect_eq("reset_pll_rst", pll_rst, 1);
    expect_eq("reset_sys_rst_n", sys_rst_n, 0);
    expect_eq("reset_state", state_o, 0);
    rst_n = 1'b1;

    // bring-up, lock loss in RUN, unstable lock in STABLE
    for (int r = 0; r < 19; r++) begin
      run(tbl[r].lk, tbl[r].n);
      expect_eq($sformatf("tbl%0d_state", r), state_o, tbl[r].st);
      expect_eq($sformatf("tbl%0d_pll_rst", r), pll_rst, tbl[r].prst);
      expect_eq($sformatf("tbl%0d_sys_rst_n", r), sys_rst_n, tbl[r].srst);
      expect_eq($sformatf("tbl%0d_ready", r), pll_ready, tbl[r].srst);
      expect_eq($sformatf("tbl%0d_loss", r), lock_loss_cnt, tbl[r].loss);
    end

    // lock lost for good: two pulses, two waits, then FAIL
    prev = pll_rst;
    len = 1;
    for (int i = 0; i < 120; i++) begin
      cyc(1'b0);
      if (pll_rst == prev) len++;
      else begin
        runs.push_back(len);
        prev = pll_rst;
        len = 1;
      end
    end
    while (runs.size() < 5) runs.push_back(-1);
    expect_eq("retry_pulse1", runs[1], RSTC);
    expect_eq("retry_wait1", runs[2], TOC);
    expect_eq("retry_pulse2", runs[3], RSTC);
    expect_eq("retry_wait2", runs[4], TOC);
    run(1'b1, 20);
    expect_eq("fail_state", state_o, 4);
    expect_eq("fail_flag", pll_fail, 1);
    expect_eq("fail_pll_rst", pll_rst, 1);
    do_reset();
    expect_eq("fail_cleared", pll_fail, 0);

    // lock_s lands on the last WAIT_LOCK cycle after one timeout
    run(1'b0, 69);
    run(1'b1, 2);
    expect_eq("bnd_hit_pre", state_o, 1);
    cyc(1'b1);
    expect_eq("bnd_hit_state", state_o, 2);
    run(1'b1, 8);
    expect_eq("bnd_hit_run", state_o, 3);

    // lock_s one cycle too late: timeout wins
    do_reset();
    run(1'b0, 34);
    cyc(1'b1);
    expect_eq("bnd_miss_pre", state_o, 1);
    cyc(1'b1);
    expect_eq("bnd_miss_state", state_o, 0);

    // repeated lock losses saturate the counter
    do_reset();
    run(1'b1, 20);
    expect_eq("sat_start", state_o, 3);
    for (int k = 0; k < 300; k++) begin
      cyc(1'b0);
      run(1'b1, 25);
    end
    expect_eq("sat_state", state_o, 3);
    expect_eq("sat_loss", lock_loss_cnt, LE ? SAT : 0);

    // asynchronous reset in the middle of STABLE
    do_reset();
    run(1'b0, 4);
    run(1'b1, 5);
    expect_eq("async_pre", state_o, 2);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    expect_eq("async_state", state_o, 0);
    expect_eq("async_pll_rst", pll_rst, 1);
    expect_eq("async_sys", sys_rst_n, 0);
    expect_eq("async_loss", lock_loss_cnt, 0);
    @(negedge clk);
    run(1'b0, 2);
    rst_n = 1'b1;
    run(1'b1, 20);
    expect_eq("async_rerun", state_o, 3);

    // random lock segments with occasional resets
    seg = 0;
    rl = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        if (seg == 0) begin
          rl = ($urandom_range(0, 4) != 0);
          seg = rl ? int'($urandom_range(1, 60))
                   : int'($urandom_range(1, 45));
        end
        cyc(rl);
        seg--;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
